up_tag_arbiter: RTL and testbench
=================================

Name: up_tag_arbiter

Overview:
- Shares the single upstream memory port of the TLP processor (up_read/up_write/up_txtag/up_address/up_writedata in; up_rxtag/up_readdata/up_ack/up_err back) among NUM_REQ local requesters.
- Round-robin arbitration between requesters.
- Allocates read tags from a free pool and routes each completion back to the requester that issued it.
- Sits between the DMA/engine clients and the TLP processor upstream port, in the pcie_clk domain.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- NUM_TAGS, 32: usable tag count (1..32); tags 0..NUM_TAGS-1.
- TIMEOUT_CYCLES, 65535: completion timeout in pcie_clk cycles. Used only when UP_TAG_TIMEOUT_EN is defined.

Ports:
- pcie_clk  in  1  clock
- pcie_rst  in  1  reset, asynchronous, active-high
- req_read  in  NUM_REQ  per-requester read request, level; held until granted
- req_write  in  NUM_REQ  per-requester write request, level; held until granted
- req_address  in  NUM_REQ*64  per-requester byte address; slice i belongs to requester i
- req_writedata  in  NUM_REQ*64  per-requester write data
- req_gnt  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted into issue slot
- rsp_valid  out  NUM_REQ  one-hot, 1-cycle pulse: read completion for requester i
- rsp_readdata  out  64  completion data, valid with rsp_valid
- rsp_err  out  3  completion status, valid with rsp_valid (0 = OK)
- up_read  out  1  to TLP processor
- up_write  out  1  to TLP processor
- up_txtag  out  5  to TLP processor
- up_address  out  64  to TLP processor
- up_writedata  out  64  to TLP processor
- up_wait  in  1  TLP processor upstream FIFO full
- up_rxtag  in  5  completion tag
- up_readdata  in  64  completion data
- up_ack  in  1  completion strobe
- up_err  in  3  completion status
- tags_busy  out  6  count of outstanding tags
- unexp_cnt  out  8  saturating count of completions for non-outstanding tags

Behaviour:
- Reset values: req_gnt=0, rsp_valid=0, rsp_readdata=0, rsp_err=0, issue slot empty (up_read=up_write=0), up_txtag=0, up_address=0, up_writedata=0, all tags free, tags_busy=0, unexp_cnt=0, round-robin pointer=0.
- Issue slot:
  - One registered entry holding {is_read, tag, address, writedata}.
  - up_read = slot_valid & is_read & ~up_wait; up_write = slot_valid & ~is_read & ~up_wait.
  - The slot clears on the cycle it fires. up_address/up_writedata/up_txtag drive the slot contents.
- Arbitration:
  - Runs when the slot is empty, or is firing this cycle (back-to-back issue: 1 request/cycle when up_wait=0).
  - Eligible = req_write[i] | (req_read[i] & tag_available).
  - Round-robin starts at pointer; the winner gets req_gnt pulse in the same cycle it loads the slot. Pointer advances to winner+1 mod NUM_REQ.
  - If a requester asserts both read and write, read has priority.
  - Latency from request (slot empty, up_wait=0) to req_gnt is 0 cycles; to up_read/up_write is 1 cycle.
- Tag allocation (reads only):
  - The lowest-index free tag is marked busy at grant, and the requester index is stored in owner_ram[tag].
  - Writes are posted: up_txtag=0, no tag consumed.
  - With no free tag, reads are ineligible and writes still proceed.
- Completion:
  - On up_ack with tag busy: rsp_valid[owner_ram[up_rxtag]] pulses the next cycle, with rsp_readdata=up_readdata and rsp_err=up_err (an error of 3'b111 passes through unchanged). The tag is freed.
  - On up_ack with tag free or tag>=NUM_TAGS: no rsp, unexp_cnt increments (saturates at 255).
- Same cycle free + allocate: allocation sees the pre-free bitmap; the freed tag is available the next cycle.
- tags_busy is registered popcount of the busy map; it updates the cycle after grant/free.
- Reset mid-operation: slot dropped and all tags freed. No rsp emitted for outstanding reads; their later completions count as unexpected.

Optional Feature:
- Macro UP_TAG_TIMEOUT_EN.
- Defined:
  - Each busy tag has a counter cleared at allocation.
  - At TIMEOUT_CYCLES it emits rsp_valid to the owner with rsp_err=3'b110 and rsp_readdata=0, and frees the tag.
  - A real completion has priority the same cycle; the timeout retries next cycle.
  - One timeout rsp per cycle, lowest tag first.
  - A late completion after timeout counts as unexpected.
- Undefined: no counters; tags stay busy until completed.

Decomposition:
- Package up_tag_pkg: tag width constant (5), rsp_err code constants (OK=0, TIMEOUT=3'b110, LEN_ERR=3'b111), issue-slot struct typedef.
- Sub-module up_tag_pool: free bitmap, lowest-free priority encoder, owner RAM, busy count, optional timeout counters.

Test Plan:
- Single read from req 2, addr 0x1000, up_wait=0: req_gnt=4'b0100, next cycle up_read=1, up_txtag=0. Then ack tag 0 with data 0xDEADBEEF_CAFEF00D, err 0 → rsp_valid=4'b0100 with that data one cycle later.
- All 4 requesters read continuously: grants rotate 0,1,2,3,0; tags 0..31 issued in order; 33rd read stalls while a concurrent write still issues with up_txtag=0.
- up_wait=1 for 5 cycles with slot loaded: up_read=0 and no new req_gnt; on release, up_read fires once and the next grant comes the same cycle.
- Ack tag 7 when not outstanding → no rsp_valid, unexp_cnt=1. Ack with up_err=3'b111 on a busy tag → rsp_err=3'b111 to owner.
- Assert pcie_rst with 3 tags busy → tags_busy=0, up_read=0 immediately; post-reset ack on old tag → unexp_cnt=1.
- With UP_TAG_TIMEOUT_EN and TIMEOUT_CYCLES=100: unanswered read → rsp_err=3'b110 after 100 cycles, tag freed; late ack → unexp_cnt increments.

Source files
------------

// File: rtl/up_tag_pkg.sv
// Shared types and constants for the upstream tag arbiter.
package up_tag_pkg;

  localparam int unsigned TAG_W     = 5;
  localparam int unsigned TAG_SPACE = 2 ** TAG_W;
  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned ERR_W     = 3;
  localparam int unsigned BUSY_W    = 6;
  localparam int unsigned UNEXP_W   = 8;

  localparam logic [ERR_W-1:0] RSP_OK      = 3'b000;
  localparam logic [ERR_W-1:0] RSP_TIMEOUT = 3'b110;
  localparam logic [ERR_W-1:0] RSP_LEN_ERR = 3'b111;

  typedef struct packed {
    logic              is_read;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
  } issue_slot_t;

  function automatic logic [BUSY_W-1:0] popcount_tags(input logic [TAG_SPACE-1:0] v);
    logic [BUSY_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(TAG_SPACE); i++) n = n + BUSY_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/up_tag_pool.sv
// Read-tag pool: free bitmap, lowest-free allocation, owner RAM and completion routing.
// Completion timeouts are compiled in when UP_TAG_TIMEOUT_EN is defined.
module up_tag_pool
  import up_tag_pkg::*;
#(
  parameter  int unsigned NUM_REQ        = 4,
  parameter  int unsigned NUM_TAGS       = 32,
  parameter  int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned OWN_W          = $clog2(NUM_REQ)
) (
  input  logic               pcie_clk,
  input  logic               pcie_rst,
  input  logic               alloc_en,
  input  logic [OWN_W-1:0]   alloc_owner,
  output logic               tag_avail_c,
  output logic [TAG_W-1:0]   alloc_tag_c,
  input  logic               up_ack,
  input  logic [TAG_W-1:0]   up_rxtag,
  input  logic [DATA_W-1:0]  up_readdata,
  input  logic [ERR_W-1:0]   up_err,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [DATA_W-1:0]  rsp_readdata,
  output logic [ERR_W-1:0]   rsp_err,
  output logic [BUSY_W-1:0]  tags_busy,
  output logic [UNEXP_W-1:0] unexp_cnt
);

  // Tags at or above NUM_TAGS are never marked busy, so they always miss.
  localparam logic [TAG_SPACE-1:0] TAG_MASK = TAG_SPACE'((64'd1 << NUM_TAGS) - 64'd1);

  logic [TAG_SPACE-1:0] busy_q, busy_d, free_bits;
  logic [OWN_W-1:0]     owner_ram [TAG_SPACE];
  logic                 hit;
  logic                 tmo_fire;
  logic [TAG_W-1:0]     tmo_tag;

  assign free_bits   = ~busy_q & TAG_MASK;
  assign tag_avail_c = |free_bits;
  assign hit         = up_ack & busy_q[up_rxtag];

  // Lowest-index free tag, taken from the pre-free bitmap.
  always_comb begin
    alloc_tag_c = '0;
    for (int t = int'(TAG_SPACE) - 1; t >= 0; t--)
      if (free_bits[TAG_W'(t)]) alloc_tag_c = TAG_W'(t);
  end

`ifdef UP_TAG_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt [TAG_SPACE];
  logic             tmo_any;

  // Lowest expired tag; a real completion owns the response port this cycle.
  always_comb begin
    tmo_any = 1'b0;
    tmo_tag = '0;
    for (int t = int'(TAG_SPACE) - 1; t >= 0; t--)
      if (busy_q[TAG_W'(t)] && tmo_cnt[TAG_W'(t)] == CNT_W'(TIMEOUT_CYCLES)) begin
        tmo_any = 1'b1;
        tmo_tag = TAG_W'(t);
      end
  end
  assign tmo_fire = tmo_any & ~hit;

  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      for (int t = 0; t < int'(TAG_SPACE); t++) tmo_cnt[TAG_W'(t)] <= '0;
    end else begin
      for (int t = 0; t < int'(TAG_SPACE); t++)
        if (alloc_en && alloc_tag_c == TAG_W'(t))
          tmo_cnt[TAG_W'(t)] <= '0;
        else if (busy_q[TAG_W'(t)] && tmo_cnt[TAG_W'(t)] != CNT_W'(TIMEOUT_CYCLES))
          tmo_cnt[TAG_W'(t)] <= tmo_cnt[TAG_W'(t)] + CNT_W'(1);
    end
  end
`else
  // No timeouts: tags stay busy until their completion arrives.
  assign tmo_fire = 1'b0 & (TIMEOUT_CYCLES != 0);
  assign tmo_tag  = '0;
`endif

  always_comb begin
    busy_d = busy_q;
    if (hit)      busy_d[up_rxtag]    = 1'b0;
    if (tmo_fire) busy_d[tmo_tag]     = 1'b0;
    if (alloc_en) busy_d[alloc_tag_c] = 1'b1;
  end

  always_ff @(posedge pcie_clk) begin
    if (alloc_en) owner_ram[alloc_tag_c] <= alloc_owner;
  end

  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      busy_q       <= '0;
      tags_busy    <= '0;
      unexp_cnt    <= '0;
      rsp_valid    <= '0;
      rsp_readdata <= '0;
      rsp_err      <= RSP_OK;
    end else begin
      busy_q    <= busy_d;
      tags_busy <= popcount_tags(busy_d);
      rsp_valid <= '0;
      if (hit) begin
        rsp_valid    <= NUM_REQ'(1) << owner_ram[up_rxtag];
        rsp_readdata <= up_readdata;
        rsp_err      <= up_err;
      end else if (tmo_fire) begin
        rsp_valid    <= NUM_REQ'(1) << owner_ram[tmo_tag];
        rsp_readdata <= '0;
        rsp_err      <= RSP_TIMEOUT;
      end
      if (up_ack && !hit && unexp_cnt != {UNEXP_W{1'b1}})
        unexp_cnt <= unexp_cnt + UNEXP_W'(1);
    end
  end

endmodule

// File: rtl/up_tag_arbiter.sv
// Round-robin arbiter sharing the TLP processor upstream port among NUM_REQ requesters.
// Optional completion timeout enabled by defining UP_TAG_TIMEOUT_EN.
module up_tag_arbiter
  import up_tag_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned NUM_TAGS       = 32,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                      pcie_clk,
  input  logic                      pcie_rst,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  output logic [NUM_REQ-1:0]        req_gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_readdata,
  output logic [ERR_W-1:0]          rsp_err,
  output logic                      up_read,
  output logic                      up_write,
  output logic [TAG_W-1:0]          up_txtag,
  output logic [ADDR_W-1:0]         up_address,
  output logic [DATA_W-1:0]         up_writedata,
  input  logic                      up_wait,
  input  logic [TAG_W-1:0]          up_rxtag,
  input  logic [DATA_W-1:0]         up_readdata,
  input  logic                      up_ack,
  input  logic [ERR_W-1:0]          up_err,
  output logic [BUSY_W-1:0]         tags_busy,
  output logic [UNEXP_W-1:0]        unexp_cnt
);

  localparam int unsigned OWN_W = $clog2(NUM_REQ);

  issue_slot_t        slot_q, slot_d;
  logic               slot_valid;
  logic               fire, arb_en, tag_avail, win_valid, win_read;
  logic [OWN_W-1:0]   rr_ptr, win;
  logic [TAG_W-1:0]   alloc_tag;
  logic [NUM_REQ-1:0] eligible;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
  int unsigned        rr_idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
    assign addr_arr[g]  = req_address[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_writedata[g*DATA_W +: DATA_W];
  end

  assign fire         = slot_valid & ~up_wait;
  assign up_read      = fire & slot_q.is_read;
  assign up_write     = fire & ~slot_q.is_read;
  assign up_txtag     = slot_q.tag;
  assign up_address   = slot_q.address;
  assign up_writedata = slot_q.writedata;

  // Slot can accept a new request when empty or emptying this cycle.
  assign arb_en   = (~slot_valid | fire) & ~pcie_rst;
  assign eligible = req_write | (req_read & {NUM_REQ{tag_avail}});

  always_comb begin
    win_valid = 1'b0;
    win       = '0;
    rr_idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rr_idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (arb_en && !win_valid && eligible[OWN_W'(rr_idx)]) begin
        win_valid = 1'b1;
        win       = OWN_W'(rr_idx);
      end
    end
  end

  // Read wins over write when a requester asserts both and a tag is free.
  assign win_read = win_valid & req_read[win] & tag_avail;
  assign req_gnt  = win_valid ? (NUM_REQ'(1) << win) : '0;

  always_comb begin
    slot_d.is_read   = win_read;
    slot_d.tag       = win_read ? alloc_tag : '0;
    slot_d.address   = addr_arr[win];
    slot_d.writedata = wdata_arr[win];
  end

  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      slot_valid <= 1'b0;
      slot_q     <= '0;
      rr_ptr     <= '0;
    end else begin
      if (fire) slot_valid <= 1'b0;
      if (win_valid) begin
        slot_valid <= 1'b1;
        slot_q     <= slot_d;
        rr_ptr     <= (win == OWN_W'(NUM_REQ - 1)) ? '0 : win + OWN_W'(1);
      end
    end
  end

  up_tag_pool #(
    .NUM_REQ        (NUM_REQ),
    .NUM_TAGS       (NUM_TAGS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_pool (
    .pcie_clk     (pcie_clk),
    .pcie_rst     (pcie_rst),
    .alloc_en     (win_read),
    .alloc_owner  (win),
    .tag_avail_c  (tag_avail),
    .alloc_tag_c  (alloc_tag),
    .up_ack       (up_ack),
    .up_rxtag     (up_rxtag),
    .up_readdata  (up_readdata),
    .up_err       (up_err),
    .rsp_valid    (rsp_valid),
    .rsp_readdata (rsp_readdata),
    .rsp_err      (rsp_err),
    .tags_busy    (tags_busy),
    .unexp_cnt    (unexp_cnt)
  );

endmodule

// File: tb/tb_up_tag_arbiter.sv
// Bench for up_tag_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_up_tag_arbiter;

  localparam int NREQ  = 4;
  localparam int NTAGS = 32;

  logic              pcie_clk, pcie_rst;
  logic [NREQ-1:0]   req_read, req_write, req_gnt, rsp_valid;
  logic [NREQ*64-1:0] req_address, req_writedata;
  logic [63:0]       rsp_readdata, up_address, up_writedata, up_readdata;
  logic [2:0]        rsp_err, up_err;
  logic              up_read, up_write, up_wait, up_ack;
  logic [4:0]        up_txtag, up_rxtag;
  logic [5:0]        tags_busy;
  logic [7:0]        unexp_cnt;

  int errors = 0;
  int checks = 0;
  bit ack_en = 0;

  // Model state: issue slot, tag ownership, pending response, counters.
  bit          m_sv, m_srd;
  logic [4:0]  m_stag;
  logic [63:0] m_saddr, m_swd, m_rsp_d;
  logic [2:0]  m_rsp_e;
  logic [NREQ-1:0] m_rsp_v, granted;
  bit          m_busy [32];
  int          m_owner [32];
  int          m_ptr, m_unexp;
  int          issued [$];

  up_tag_arbiter #(.NUM_REQ(NREQ), .NUM_TAGS(NTAGS)) dut (
    .pcie_clk(pcie_clk), .pcie_rst(pcie_rst),
    .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_writedata(req_writedata),
    .req_gnt(req_gnt), .rsp_valid(rsp_valid),
    .rsp_readdata(rsp_readdata), .rsp_err(rsp_err),
    .up_read(up_read), .up_write(up_write), .up_txtag(up_txtag),
    .up_address(up_address), .up_writedata(up_writedata),
    .up_wait(up_wait), .up_rxtag(up_rxtag), .up_readdata(up_readdata),
    .up_ack(up_ack), .up_err(up_err),
    .tags_busy(tags_busy), .unexp_cnt(unexp_cnt)
  );

  initial pcie_clk = 1'b0;
  always #5 pcie_clk = ~pcie_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_sv = 0; m_srd = 0; m_stag = '0; m_saddr = '0; m_swd = '0;
    m_rsp_v = '0; m_rsp_d = '0; m_rsp_e = '0; m_ptr = 0; m_unexp = 0;
    for (int t = 0; t < 32; t++) begin m_busy[t] = 0; m_owner[t] = 0; end
  endfunction

  // Compare DUT against the model on every falling edge, then advance the model.
  always @(negedge pcie_clk) begin
    int win, lowest, idx, nbusy;
    bit fire, avail, hit;
    logic [NREQ-1:0] e_gnt;
    if (pcie_rst) begin
      model_reset();
      granted = '0;
      check("rst_gnt", 64'(req_gnt), 64'(0));
      check("rst_up_read", 64'(up_read), 64'(0));
      check("rst_up_write", 64'(up_write), 64'(0));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_tags_busy", 64'(tags_busy), 64'(0));
      check("rst_unexp", 64'(unexp_cnt), 64'(0));
    end else begin
      fire = m_sv && !up_wait;
      avail = 0; lowest = -1; nbusy = 0;
      for (int t = 0; t < 32; t++) begin
        if (m_busy[t]) nbusy++;
        if (t < NTAGS && !m_busy[t]) begin
          avail = 1;
          if (lowest < 0) lowest = t;
        end
      end
      win = -1;
      if (!m_sv || fire)
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (win < 0 && (req_write[idx] || (req_read[idx] && avail))) win = idx;
        end
      e_gnt = (win >= 0) ? (NREQ'(1) << win) : '0;

      check("gnt", 64'(req_gnt), 64'(e_gnt));
      check("up_read", 64'(up_read), 64'(fire && m_srd));
      check("up_write", 64'(up_write), 64'(fire && !m_srd));
      check("up_txtag", 64'(up_txtag), 64'(m_stag));
      check("up_address", up_address, m_saddr);
      check("up_writedata", up_writedata, m_swd);
      check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_v));
      if (m_rsp_v != '0) begin
        check("rsp_readdata", rsp_readdata, m_rsp_d);
        check("rsp_err", 64'(rsp_err), 64'(m_rsp_e));
      end
      check("tags_busy", 64'(tags_busy), 64'(nbusy));
      check("unexp_cnt", 64'(unexp_cnt), 64'(m_unexp));

      granted = e_gnt;
      if (fire && m_srd) issued.push_back(int'(m_stag));
      if (fire) m_sv = 0;
      hit = up_ack && (int'(up_rxtag) < NTAGS) && m_busy[up_rxtag];
      m_rsp_v = '0;
      if (hit) begin
        m_rsp_v = NREQ'(1) << m_owner[up_rxtag];
        m_rsp_d = up_readdata;
        m_rsp_e = up_err;
        m_busy[up_rxtag] = 0;
      end else if (up_ack && m_unexp < 255) begin
        m_unexp++;
      end
      if (win >= 0) begin
        m_sv    = 1;
        m_srd   = req_read[win] && avail;
        m_stag  = m_srd ? 5'(lowest) : 5'd0;
        m_saddr = req_address[win*64 +: 64];
        m_swd   = req_writedata[win*64 +: 64];
        if (m_srd) begin m_busy[lowest] = 1; m_owner[lowest] = win; end
        m_ptr = (win + 1) % NREQ;
      end
    end
  end

  task automatic cyc();
    @(posedge pcie_clk);
    #1;
  endtask

  task automatic ack(input int tag, input logic [63:0] d, input logic [2:0] e);
    up_ack = 1'b1; up_rxtag = 5'(tag); up_readdata = d; up_err = e;
  endtask

  task automatic drive_random();
    int j;
    up_wait = ($urandom_range(0, 3) == 0);
    up_ack  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (granted[i] || !(req_read[i] || req_write[i])) begin
        req_read[i] = 1'b0; req_write[i] = 1'b0;
        if ($urandom_range(0, 99) < 70) begin
          case ($urandom_range(0, 9))
            0, 1:    req_write[i] = 1'b1;
            2:       begin req_read[i] = 1'b1; req_write[i] = 1'b1; end
            default: req_read[i] = 1'b1;
          endcase
          req_address[i*64 +: 64]   = {$urandom, $urandom};
          req_writedata[i*64 +: 64] = {$urandom, $urandom};
        end
      end
    end
    if (ack_en) begin
      if (issued.size() > 0 && $urandom_range(0, 2) != 0) begin
        j = $urandom_range(0, issued.size() - 1);
        ack(issued[j], {$urandom, $urandom}, 3'($urandom_range(0, 7)));
        issued.delete(j);
      end else if ($urandom_range(0, 40) == 0) begin
        ack($urandom_range(0, 31), {$urandom, $urandom}, 3'($urandom_range(0, 7)));
      end
    end
  endtask

  logic [3:0] rot [5];

  initial begin
    rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    pcie_rst = 1'b1; req_read = '0; req_write = '0; req_address = '0; req_writedata = '0;
    up_wait = 1'b0; up_ack = 1'b0; up_rxtag = '0; up_readdata = '0; up_err = '0;
    repeat (3) cyc();
    @(negedge pcie_clk);
    check("lit_rst_busy", 64'(tags_busy), 64'd0);
    cyc(); pcie_rst = 1'b0;

    // Single read from requester 2, then its completion.
    cyc(); req_read[2] = 1'b1; req_address[2*64 +: 64] = 64'h1000;
    @(negedge pcie_clk); check("lit_gnt_req2", 64'(req_gnt), 64'h4);
    cyc(); req_read[2] = 1'b0;
    @(negedge pcie_clk);
    check("lit_up_read", 64'(up_read), 64'd1);
    check("lit_txtag0", 64'(up_txtag), 64'd0);
    check("lit_addr", up_address, 64'h1000);
    cyc(); ack(0, 64'hDEADBEEF_CAFEF00D, 3'd0);
    cyc(); up_ack = 1'b0;
    @(negedge pcie_clk);
    check("lit_rsp_valid", 64'(rsp_valid), 64'h4);
    check("lit_rsp_data", rsp_readdata, 64'hDEADBEEF_CAFEF00D);
    check("lit_rsp_err", 64'(rsp_err), 64'd0);

    // Completion for a tag nobody owns.
    cyc(); ack(7, 64'h55, 3'd0);
    cyc(); up_ack = 1'b0;
    @(negedge pcie_clk);
    check("lit_unexp_rsp", 64'(rsp_valid), 64'd0);
    check("lit_unexp_cnt", 64'(unexp_cnt), 64'd1);

    // Error status 3'b111 passes through to the owner.
    cyc(); req_read[1] = 1'b1;
    @(negedge pcie_clk); check("lit_gnt_req1", 64'(req_gnt), 64'h2);
    cyc(); req_read[1] = 1'b0;
    cyc(); ack(0, 64'h1234, 3'b111);
    cyc(); up_ack = 1'b0;
    @(negedge pcie_clk);
    check("lit_err_valid", 64'(rsp_valid), 64'h2);
    check("lit_err_code", 64'(rsp_err), 64'h7);

    // Backpressure holds the slot and blocks further grants.
    cyc(); up_wait = 1'b1; req_read[0] = 1'b1; req_read[3] = 1'b1;
    @(negedge pcie_clk); check("lit_gnt_req3", 64'(req_gnt), 64'h8);
    cyc(); req_read[3] = 1'b0;
    repeat (5) begin
      @(negedge pcie_clk);
      check("lit_wait_read", 64'(up_read), 64'd0);
      check("lit_wait_gnt", 64'(req_gnt), 64'd0);
      cyc();
    end
    up_wait = 1'b0;
    @(negedge pcie_clk);
    check("lit_release_read", 64'(up_read), 64'd1);
    check("lit_release_gnt", 64'(req_gnt), 64'h1);

    // Reset with three tags outstanding.
    cyc(); req_read[0] = 1'b0; req_read[2] = 1'b1;
    @(negedge pcie_clk); check("lit_gnt_b2b", 64'(req_gnt), 64'h4);
    cyc(); req_read[2] = 1'b0;
    check("lit_busy3", 64'(tags_busy), 64'd3);
    pcie_rst = 1'b1;
    #1;
    check("lit_rst_up_read", 64'(up_read), 64'd0);
    check("lit_rst_tags", 64'(tags_busy), 64'd0);
    cyc(); cyc(); pcie_rst = 1'b0;
    cyc(); ack(1, 64'h99, 3'd0);
    cyc(); up_ack = 1'b0;
    @(negedge pcie_clk);
    check("lit_post_rst_unexp", 64'(unexp_cnt), 64'd1);
    check("lit_post_rst_rsp", 64'(rsp_valid), 64'd0);

    // All requesters reading continuously rotate round-robin.
    cyc(); req_read = '1;
    for (int n = 0; n < 5; n++) begin
      @(negedge pcie_clk); check("lit_rotate", 64'(req_gnt), 64'(rot[n]));
      cyc();
    end
    req_read = '0;

    // Exhaust the tag pool with no completions; writes keep flowing.
    ack_en = 0;
    repeat (150) begin cyc(); drive_random(); end
    @(negedge pcie_clk); check("lit_pool_full", 64'(tags_busy), 64'd32);

    ack_en = 1;
    repeat (2500) begin cyc(); drive_random(); end
    cyc(); req_read = '0; req_write = '0; up_ack = 1'b0; up_wait = 1'b0;
    repeat (4) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
